msg_sched: RTL

MSG_SCHED -- requirements
Module: msg_sched

---
 rtl/msg_sched_pkg.sv | 14 +
 rtl/sha256_pkg.sv | 45 ++++
 rtl/msg_sched_expand.sv | 22 ++
 rtl/msg_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_sched_pkg.sv
// ---------------------------------------------------------------------------
// msg_sched_pkg
// Local types for the message scheduler: the control FSM state encoding.
// ---------------------------------------------------------------------------
package msg_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 constants and helpers used by the hashing datapath:
//   K      : 64-entry round-constant table
//   IV     : 8 initial hash values
//   sigma0 : small sigma0 of the message schedule (ror7 ^ ror18 ^ shr3)
//   sigma1 : small sigma1 of the message schedule (ror17 ^ ror19 ^ shr10)
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // ror7 ^ ror18 ^ shr3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // ror17 ^ ror19 ^ shr10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

endpackage

// File: rtl/msg_sched_expand.sv
// ---------------------------------------------------------------------------
// msg_sched_expand
// Combinational schedule expansion for one new word. With four interleaved
// lanes, W[t-2], W[t-7], W[t-15], W[t-16] of the same lane sit at ages
// 8, 28, 60 and 64 of the shared shift register.
// Ports:
//   tap8_i, tap28_i, tap60_i, tap64_i : shift-register taps (by age)
//   w_o                               : sigma1(t8)+t28+sigma0(t60)+t64 mod 2^32
// ---------------------------------------------------------------------------
module msg_sched_expand
  import sha256_pkg::*;
(
  input  logic [31:0] tap8_i,
  input  logic [31:0] tap28_i,
  input  logic [31:0] tap60_i,
  input  logic [31:0] tap64_i,
  output logic [31:0] w_o
);

  assign w_o = sigma1(tap8_i) + tap28_i + sigma0(tap60_i) + tap64_i;

endmodule

// File: rtl/msg_sched.sv
// ---------------------------------------------------------------------------
// msg_sched
// Four-lane interleaved SHA-256 message scheduler. Loads 64 words (16 per
// lane), then streams 256 schedule words with their round constants, then
// issues the chunk-finalize strobe and a completion pulse.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   new_msg_i               : sampled with word 0 only; starts a 4-cycle clr_o
//   blk_valid_i/blk_word_i  : input word stream, accepted with blk_ready_o
//   blk_ready_o             : high in IDLE and LOAD
//   w_o, k_o                : registered schedule word / round constant
//   clr_o, update_o         : hash-restart / chunk-finalize strobes
//   busy_o, done_o          : busy in LOAD/RUN/FLUSH, one-cycle completion
//   chunk_cnt_o             : completed-chunk count
// Parameter:
//   UPD_DLY (>=1)           : cycles from RUN cycle 255 to first update_o
// Build option:
//   MSG_SCHED_STAT_EN       : when defined, chunk_cnt_o counts done pulses;
//                             otherwise chunk_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module msg_sched
  import sha256_pkg::*;
  import msg_sched_pkg::*;
#(
  parameter int unsigned UPD_DLY = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        new_msg_i,
  input  logic        blk_valid_i,
  input  logic [31:0] blk_word_i,
  output logic        blk_ready_o,
  output logic [31:0] w_o,
  output logic [31:0] k_o,
  output logic        clr_o,
  output logic        update_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] chunk_cnt_o
);

  // FLUSH counter must reach UPD_DLY+2
  localparam int unsigned FW = $clog2(UPD_DLY + 5);

  state_e          state_q, state_d;
  logic [5:0]      wcnt_q, wcnt_d;
  logic [7:0]      ncnt_q, ncnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [2:0]      clr_cnt_q, clr_cnt_d;
  logic [31:0]     sr_q [64];
  logic [31:0]     w_q, w_d;
  logic [31:0]     k_q, k_d;
  logic            clr_q, update_q, update_d, busy_q, done_q, done_d, ready_q;
  logic            hs_s, shift_en_s;
  logic [31:0]     shift_in_s, w_exp_s, dist_s;

  // True when a cycle at distance d from RUN cycle 255 carries update_o.
  function automatic logic in_upd_win(input logic [31:0] d);
    return (d >= UPD_DLY) && (d < UPD_DLY + 32'd4);
  endfunction

  assign hs_s = blk_valid_i & ready_q;

  // sr_q index i holds age i+1
  msg_sched_expand u_expand (
    .tap8_i  (sr_q[7]),
    .tap28_i (sr_q[27]),
    .tap60_i (sr_q[59]),
    .tap64_i (sr_q[63]),
    .w_o     (w_exp_s)
  );

  // Next-state, datapath select and strobe timing.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ncnt_d     = ncnt_q;
    fcnt_d     = fcnt_q;
    clr_cnt_d  = (clr_cnt_q != 3'd0) ? (clr_cnt_q - 3'd1) : 3'd0;
    shift_en_s = 1'b0;
    shift_in_s = blk_word_i;
    w_d        = 32'd0;
    k_d        = 32'd0;
    update_d   = 1'b0;
    done_d     = 1'b0;
    dist_s     = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          shift_en_s = 1'b1;
          wcnt_d     = 6'd1;
          state_d    = ST_LOAD;
          // clr_o runs 4 cycles starting the cycle after word 0
          clr_cnt_d  = new_msg_i ? 3'd4 : 3'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (hs_s) begin
          shift_en_s = 1'b1;
          wcnt_d     = wcnt_q + 6'd1;
          if (wcnt_q == 6'd63) begin
            state_d = ST_RUN;
            ncnt_d  = 8'd0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_RUN: begin
        shift_en_s = 1'b1;
        // first 64 cycles replay the loaded words by rotating the register
        shift_in_s = (ncnt_q[7:6] == 2'b00) ? sr_q[63] : w_exp_s;
        w_d        = shift_in_s;
        k_d        = K[ncnt_q[7:2]];
        ncnt_d     = ncnt_q + 8'd1;
        if (ncnt_q == 8'd255) begin
          state_d  = ST_FLUSH;
          fcnt_d   = {FW{1'b0}};
          update_d = in_upd_win(32'd1);
        end else begin
          state_d  = ST_RUN;
        end
      end

      ST_FLUSH: begin
        // first FLUSH cycle is distance 1 from RUN cycle 255
        dist_s   = 32'(fcnt_q) + 32'd1;
        fcnt_d   = fcnt_q + FW'(1'b1);
        update_d = in_upd_win(dist_s + 32'd1);
        done_d   = (dist_s == UPD_DLY + 32'd2);
        if (dist_s == UPD_DLY + 32'd3) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 6'd0;
      ncnt_q    <= 8'd0;
      fcnt_q    <= {FW{1'b0}};
      clr_cnt_q <= 3'd0;
      w_q       <= 32'd0;
      k_q       <= 32'd0;
      clr_q     <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      ncnt_q    <= ncnt_d;
      fcnt_q    <= fcnt_d;
      clr_cnt_q <= clr_cnt_d;
      w_q       <= w_d;
      k_q       <= k_d;
      clr_q     <= (clr_cnt_d != 3'd0);
      update_q  <= update_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      ready_q   <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end
  end

  // 64-entry word shift register; index 0 is the newest word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) begin
        sr_q[i] <= 32'd0;
      end
    end else if (shift_en_s) begin
      sr_q[0] <= shift_in_s;
      for (int i = 1; i < 64; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

`ifdef MSG_SCHED_STAT_EN
  logic [31:0] chunk_q;

  // Completed-chunk counter, advanced once per done pulse, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chunk_q <= 32'd0;
    end else begin
      chunk_q <= chunk_q + {31'd0, done_q};
    end
  end

  assign chunk_cnt_o = chunk_q;
`else
  assign chunk_cnt_o = 32'd0;
`endif

  assign blk_ready_o = ready_q;
  assign w_o         = w_q;
  assign k_o         = k_q;
  assign clr_o       = clr_q;
  assign update_o    = update_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
